// File: rtl/uart_rcvr_master_pkg.sv
// uart_rcvr_master_pkg: shared state encodings and constants for the UART receiver bus master.
// Receiver states include PARITY, which is reachable only when UART_RCVR_PARITY_EN is defined.
package uart_rcvr_master_pkg;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {B_IDLE, B_REQ, B_XFER, B_REL} bus_state_e;
    localparam int FIFO_DEPTH = 4;
    localparam logic CTRL_WRITE = 1'b1;
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 (or 8E1 with UART_RCVR_PARITY_EN) deserializer with centre sampling.
// Emits a byte with a one-cycle valid pulse, or a one-cycle error pulse when the byte is dropped.
module uart_rx_core
    import uart_rcvr_master_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_serial,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_frame_err
`ifdef UART_RCVR_PARITY_EN
    ,
    output logic       o_parity_err
`endif
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    rx_state_e        r_state, w_next;
    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_valid, r_ferr;
    logic             w_rx, w_half, w_full, w_stop;
    assign w_rx   = r_sync[1];
    assign w_half = r_cnt == CNT_W'(CLKS_PER_BIT / 2 - 1);
    assign w_full = r_cnt == CNT_W'(CLKS_PER_BIT - 1);
    assign w_stop = (r_state == RX_STOP) && w_full;
    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE:   w_next = w_rx ? RX_IDLE : RX_START;
            RX_START:  if (w_half) w_next = w_rx ? RX_IDLE : RX_DATA;
`ifdef UART_RCVR_PARITY_EN
            RX_DATA:   if (w_full && r_bit_idx == 3'd7) w_next = RX_PARITY;
`else
            RX_DATA:   if (w_full && r_bit_idx == 3'd7) w_next = RX_STOP;
`endif
            RX_PARITY: if (w_full) w_next = RX_STOP;
            RX_STOP:   if (w_full) w_next = RX_IDLE;
            default:   w_next = RX_IDLE;
        endcase
    end
`ifdef UART_RCVR_PARITY_EN
    logic r_par_bad, r_perr;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            if (r_state == RX_PARITY && w_full) r_par_bad <= w_rx ^ (^r_shift);
            r_perr <= w_stop && w_rx && r_par_bad;
        end
    end
    assign o_parity_err = r_perr;
`else
    logic r_par_bad;
    assign r_par_bad = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RX_IDLE;
            r_sync    <= 2'b11;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_serial};
            r_state <= w_next;
            // Counter restarts on every state change so each phase measures from its own entry.
            r_cnt   <= (r_state == RX_IDLE || r_state != w_next || w_full) ? '0 : r_cnt + 1'b1;
            if (r_state == RX_DATA && w_full) begin
                r_shift   <= {w_rx, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            r_valid <= w_stop && w_rx && !r_par_bad;
            r_ferr  <= w_stop && !w_rx;
        end
    end
    assign o_byte      = r_shift;
    assign o_valid     = r_valid;
    assign o_frame_err = r_ferr;
endmodule

// File: rtl/uart_rcvr_master.sv
// uart_rcvr_master: UART receiver feeding a 4-deep FIFO drained one byte per bus grant as SRAM writes.
// Define UART_RCVR_PARITY_EN for even-parity frames and the ParityErr output.
module uart_rcvr_master
    import uart_rcvr_master_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          ADDR_BITS    = 18,
    parameter int unsigned BASE_ADDR    = 0
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Serial_in,
    output logic        Breq,
    input  logic        Bgnt,
    inout  wire  [7:0]  DataBus,
    inout  wire  [31:0] AddressBus,
    inout  wire         ControlBus,
    output logic        Overrun,
    output logic        FrameErr
`ifdef UART_RCVR_PARITY_EN
    ,
    output logic        ParityErr
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    logic [7:0]           w_rx_byte;
    logic                 w_rx_valid, w_rx_ferr;
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]       r_count;
    logic [ADDR_BITS-1:0] r_addr;
    bus_state_e           r_bstate, w_bnext;
    logic                 r_breq, r_overrun, r_frame_err;
    logic                 w_full, w_pop, w_push, w_drive;
`ifdef UART_RCVR_PARITY_EN
    logic w_rx_perr, r_parity_err;
`endif
    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (Reset),
        .i_serial   (Serial_in),
        .o_byte     (w_rx_byte),
        .o_valid    (w_rx_valid),
        .o_frame_err(w_rx_ferr)
`ifdef UART_RCVR_PARITY_EN
        ,
        .o_parity_err(w_rx_perr)
`endif
    );
    assign w_full  = r_count == (PTR_W + 1)'(FIFO_DEPTH);
    assign w_pop   = r_bstate == B_XFER;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign w_push  = w_rx_valid && (!w_full || w_pop);
    assign w_drive = r_bstate == B_XFER;
    always_comb begin
        w_bnext = r_bstate;
        case (r_bstate)
            B_IDLE:  if (r_count != '0) w_bnext = B_REQ;
            B_REQ:   if (Bgnt) w_bnext = B_XFER;
            B_XFER:  w_bnext = B_REL;
            B_REL:   w_bnext = B_IDLE;
            default: w_bnext = B_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_rx_byte;
    end
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_bstate    <= B_IDLE;
            r_breq      <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_addr      <= ADDR_BITS'(BASE_ADDR);
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_bstate <= w_bnext;
            r_breq   <= (w_bnext == B_REQ) || (w_bnext == B_XFER);
            r_count  <= r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_pop);
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_addr   <= r_addr + 1'b1;
            end
            if (w_rx_valid && !w_push) r_overrun <= 1'b1;
            if (w_rx_ferr) r_frame_err <= 1'b1;
        end
    end
`ifdef UART_RCVR_PARITY_EN
    always_ff @(posedge clk) begin
        if (Reset) r_parity_err <= 1'b0;
        else if (w_rx_perr) r_parity_err <= 1'b1;
    end
    assign ParityErr = r_parity_err;
`endif
    assign Breq       = r_breq;
    assign Overrun    = r_overrun;
    assign FrameErr   = r_frame_err;
    assign DataBus    = w_drive ? r_mem[r_rd_ptr] : 8'bz;
    assign AddressBus = w_drive ? 32'(r_addr) : 32'bz;
    assign ControlBus = w_drive ? CTRL_WRITE : 1'bz;
endmodule

// File: tb/tb_uart_rcvr_master.sv
// tb_uart_rcvr_master: randomized frames checked against a queue model of received bytes and write addresses.
// A second instance with BASE_ADDR at the top of the address space checks counter wrap.
module tb_uart_rcvr_master;
    localparam int CPB = 16;
    logic clk = 1'b0, Reset = 1'b1, Serial_in = 1'b1, gnt = 1'b0, tie = 1'b0, par_flip = 1'b0;
    wire Breq, Bgnt, Overrun, FrameErr, ControlBus;
    wire [7:0] DataBus;
    wire [31:0] AddressBus;
    wire Breq2, Overrun2, FrameErr2, ControlBus2;
    wire [7:0] DataBus2;
    wire [31:0] AddressBus2;
    int vecs = 0, errs = 0;
    logic [7:0] q_data[$], q_data2[$];
    logic [31:0] q_addr[$], q_addr2[$];
`ifdef UART_RCVR_PARITY_EN
    wire ParityErr, ParityErr2;
`endif
    assign Bgnt = tie ? Breq : gnt;
    always #5 clk = ~clk;

    uart_rcvr_master dut (
        .clk(clk), .Reset(Reset), .Serial_in(Serial_in), .Breq(Breq), .Bgnt(Bgnt),
        .DataBus(DataBus), .AddressBus(AddressBus), .ControlBus(ControlBus),
        .Overrun(Overrun), .FrameErr(FrameErr)
`ifdef UART_RCVR_PARITY_EN
        , .ParityErr(ParityErr)
`endif
    );
    uart_rcvr_master #(.BASE_ADDR(32'h3FFFF)) dut2 (
        .clk(clk), .Reset(Reset), .Serial_in(Serial_in), .Breq(Breq2), .Bgnt(Breq2),
        .DataBus(DataBus2), .AddressBus(AddressBus2), .ControlBus(ControlBus2),
        .Overrun(Overrun2), .FrameErr(FrameErr2)
`ifdef UART_RCVR_PARITY_EN
        , .ParityErr(ParityErr2)
`endif
    );

    always @(negedge clk) begin
        if (!Reset && ControlBus === 1'b1) begin
            q_data.push_back(DataBus);
            q_addr.push_back(AddressBus);
        end
        if (!Reset && ControlBus2 === 1'b1) begin
            q_data2.push_back(DataBus2);
            q_addr2.push_back(AddressBus2);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1; Serial_in = 1'b1; tie = 1'b0; gnt = 1'b0; par_flip = 1'b0;
        tick(3);
        Reset = 1'b0;
        tick(2);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        Serial_in = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin Serial_in = b[i]; tick(CPB); end
`ifdef UART_RCVR_PARITY_EN
        Serial_in = (^b) ^ par_flip; tick(CPB);
`endif
        Serial_in = stop; tick(CPB);
        Serial_in = 1'b1;
    endtask

    task automatic wait_q1(input int target, input int budget, output bit ok);
        while (q_data.size() < target && budget > 0) begin tick(1); budget--; end
        ok = q_data.size() >= target;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Serial_in = 1'b1; tick(3);
        vecs++; if (Breq !== 1'b0) begin errs++; $display("FAIL reset_breq got %b want 0", Breq); end
        vecs++; if (Overrun !== 1'b0) begin errs++; $display("FAIL reset_overrun got %b want 0", Overrun); end
        vecs++; if (FrameErr !== 1'b0) begin errs++; $display("FAIL reset_frameerr got %b want 0", FrameErr); end
        vecs++; if (ControlBus === 1'b1) begin errs++; $display("FAIL reset_ctrl got %b want undriven", ControlBus); end
        Reset = 1'b0; tick(2);
    endtask

    task automatic test_single_a5();
        bit ok; int n0;
        do_reset(); tie = 1'b1; n0 = q_data.size();
        send_frame(8'hA5, 1'b1);
        wait_q1(n0 + 1, 100, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL a5_write got %0d writes want 1", q_data.size() - n0); end
        else begin
            vecs++; if (q_data[n0] !== 8'hA5) begin errs++; $display("FAIL a5_data got %h want a5", q_data[n0]); end
            vecs++; if (q_addr[n0] !== 32'h0) begin errs++; $display("FAIL a5_addr got %h want 0", q_addr[n0]); end
        end
        tick(50);
        vecs++; if (q_data.size() != n0 + 1) begin errs++; $display("FAIL a5_count got %0d want 1", q_data.size() - n0); end
        vecs++; if (Breq !== 1'b0) begin errs++; $display("FAIL a5_breq_idle got %b want 0", Breq); end
    endtask

    task automatic test_random_stream();
        bit ok; int n0; logic [7:0] exp[$];
        do_reset(); tie = 1'b1; n0 = q_data.size();
        for (int k = 0; k < 6; k++) begin
            exp.push_back(8'($urandom));
            send_frame(exp[k], 1'b1);
            tick($urandom_range(0, 20));
        end
        wait_q1(n0 + 6, 200, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL stream_writes got %0d want 6", q_data.size() - n0); end
        else for (int k = 0; k < 6; k++) begin
            vecs++; if (q_data[n0+k] !== exp[k] || q_addr[n0+k] !== 32'(k)) begin
                errs++; $display("FAIL stream_%0d got %h@%h want %h@%h", k, q_data[n0+k], q_addr[n0+k], exp[k], 32'(k));
            end
        end
    endtask

    task automatic test_overrun();
        bit ok; int n0; logic [7:0] exp[$]; logic exp_ovr; logic [7:0] b;
        do_reset(); tie = 1'b0; gnt = 1'b0; n0 = q_data.size(); exp_ovr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            if (exp.size() < 4) exp.push_back(b); else exp_ovr = 1'b1;
        end
        tick(30);
        vecs++; if (Overrun !== exp_ovr) begin errs++; $display("FAIL ovr_flag got %b want %b", Overrun, exp_ovr); end
        vecs++; if (Breq !== 1'b1) begin errs++; $display("FAIL ovr_breq got %b want 1", Breq); end
        vecs++; if (q_data.size() != n0) begin errs++; $display("FAIL ovr_nogrant got %0d writes want 0", q_data.size() - n0); end
        gnt = 1'b1;
        wait_q1(n0 + exp.size(), 200, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL ovr_drain got %0d writes want %0d", q_data.size() - n0, exp.size()); end
        else for (int k = 0; k < exp.size(); k++) begin
            vecs++; if (q_data[n0+k] !== exp[k] || q_addr[n0+k] !== 32'(k)) begin
                errs++; $display("FAIL ovr_%0d got %h@%h want %h@%h", k, q_data[n0+k], q_addr[n0+k], exp[k], 32'(k));
            end
        end
        tick(40);
        vecs++; if (q_data.size() != n0 + exp.size()) begin errs++; $display("FAIL ovr_extra got %0d want %0d", q_data.size() - n0, exp.size()); end
        vecs++; if (Overrun !== 1'b1) begin errs++; $display("FAIL ovr_sticky got %b want 1", Overrun); end
        gnt = 1'b0;
    endtask

    task automatic test_frame_err();
        bit ok; int n0; logic [7:0] b;
        do_reset(); tie = 1'b1; n0 = q_data.size();
        send_frame(8'($urandom), 1'b0);
        tick(40);
        vecs++; if (FrameErr !== 1'b1) begin errs++; $display("FAIL ferr_flag got %b want 1", FrameErr); end
        vecs++; if (Breq !== 1'b0) begin errs++; $display("FAIL ferr_breq got %b want 0", Breq); end
        vecs++; if (q_data.size() != n0) begin errs++; $display("FAIL ferr_nowrite got %0d want 0", q_data.size() - n0); end
        vecs++; if (Overrun !== 1'b0) begin errs++; $display("FAIL ferr_overrun got %b want 0", Overrun); end
        b = 8'($urandom);
        send_frame(b, 1'b1);
        wait_q1(n0 + 1, 100, ok);
        vecs++; if (!ok || q_data[n0] !== b || q_addr[n0] !== 32'h0) begin
            errs++; $display("FAIL ferr_next got %h@%h want %h@0", q_data[n0], q_addr[n0], b);
        end
    endtask

    task automatic test_glitch();
        bit ok; int n0; logic [7:0] b;
        do_reset(); tie = 1'b1; n0 = q_data.size();
        Serial_in = 1'b0; tick(3); Serial_in = 1'b1; tick(40);
        vecs++; if (q_data.size() != n0) begin errs++; $display("FAIL glitch_nowrite got %0d want 0", q_data.size() - n0); end
        vecs++; if (FrameErr !== 1'b0) begin errs++; $display("FAIL glitch_ferr got %b want 0", FrameErr); end
        vecs++; if (Breq !== 1'b0) begin errs++; $display("FAIL glitch_breq got %b want 0", Breq); end
        b = 8'($urandom);
        send_frame(b, 1'b1);
        wait_q1(n0 + 1, 100, ok);
        vecs++; if (!ok || q_data[n0] !== b || q_addr[n0] !== 32'h0) begin
            errs++; $display("FAIL glitch_next got %h@%h want %h@0", q_data[n0], q_addr[n0], b);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        do_reset(); tie = 1'b0; gnt = 1'b0;
        for (int k = 0; k < 5; k++) send_frame(8'($urandom), 1'b1);
        send_frame(8'($urandom), 1'b0);
        Serial_in = 1'b1; tick(20);
        vecs++; if (Overrun !== 1'b1 || FrameErr !== 1'b1 || Breq !== 1'b1) begin
            errs++; $display("FAIL mid_pre got ovr=%b ferr=%b breq=%b want 1 1 1", Overrun, FrameErr, Breq);
        end
        Serial_in = 1'b0; tick(4 * CPB);
        Reset = 1'b1; tick(1);
        vecs++; if (Breq !== 1'b0) begin errs++; $display("FAIL mid_breq got %b want 0", Breq); end
        vecs++; if (Overrun !== 1'b0) begin errs++; $display("FAIL mid_overrun got %b want 0", Overrun); end
        vecs++; if (FrameErr !== 1'b0) begin errs++; $display("FAIL mid_frameerr got %b want 0", FrameErr); end
        vecs++; if (ControlBus === 1'b1) begin errs++; $display("FAIL mid_ctrl got %b want undriven", ControlBus); end
        Serial_in = 1'b1; Reset = 1'b0; tie = 1'b1; n0 = q_data.size();
        tick(300);
        vecs++; if (q_data.size() != n0) begin errs++; $display("FAIL mid_discard got %0d writes want 0", q_data.size() - n0); end
    endtask

    task automatic test_addr_wrap();
        int n1, n2, budget; logic [7:0] b0, b1;
        do_reset(); tie = 1'b1; n1 = q_data.size(); n2 = q_data2.size();
        b0 = 8'($urandom); b1 = 8'($urandom);
        send_frame(b0, 1'b1); send_frame(b1, 1'b1);
        budget = 200;
        while ((q_data2.size() < n2 + 2 || q_data.size() < n1 + 2) && budget > 0) begin tick(1); budget--; end
        vecs++; if (q_data2.size() < n2 + 2) begin errs++; $display("FAIL wrap_writes got %0d want 2", q_data2.size() - n2); end
        else begin
            vecs++; if (q_addr2[n2] !== 32'h3FFFF || q_data2[n2] !== b0) begin
                errs++; $display("FAIL wrap_first got %h@%h want %h@3ffff", q_data2[n2], q_addr2[n2], b0);
            end
            vecs++; if (q_addr2[n2+1] !== 32'h0 || q_data2[n2+1] !== b1) begin
                errs++; $display("FAIL wrap_second got %h@%h want %h@0", q_data2[n2+1], q_addr2[n2+1], b1);
            end
        end
        vecs++; if (q_addr[n1] !== 32'h0 || q_addr[n1+1] !== 32'h1) begin
            errs++; $display("FAIL base_addrs got %h,%h want 0,1", q_addr[n1], q_addr[n1+1]);
        end
        vecs++; if (Overrun2 !== 1'b0 || FrameErr2 !== 1'b0) begin
            errs++; $display("FAIL wrap_flags got ovr=%b ferr=%b want 0 0", Overrun2, FrameErr2);
        end
    endtask

`ifdef UART_RCVR_PARITY_EN
    task automatic test_parity();
        bit ok; int n0;
        do_reset(); tie = 1'b1; n0 = q_data.size();
        par_flip = 1'b1; send_frame(8'h03, 1'b1); par_flip = 1'b0;
        tick(40);
        vecs++; if (ParityErr !== 1'b1 || q_data.size() != n0) begin
            errs++; $display("FAIL parity_bad got perr=%b writes=%0d want 1 0", ParityErr, q_data.size() - n0);
        end
        send_frame(8'h03, 1'b1);
        wait_q1(n0 + 1, 100, ok);
        vecs++; if (!ok || q_data[n0] !== 8'h03 || q_addr[n0] !== 32'h0) begin
            errs++; $display("FAIL parity_good got %h@%h want 03@0", q_data[n0], q_addr[n0]);
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_a5();
        test_random_stream();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_addr_wrap();
`ifdef UART_RCVR_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/uart_rcvr_master.md
UART_RCVR_MASTER -- requirements
Module: uart_rcvr_master

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit (minimum 4, even).
REQ-002 Parameter ADDR_BITS, default 18, meaning width of the internal write-address counter (SRAM space).
REQ-003 Parameter BASE_ADDR, default 0, meaning first write address after reset.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Serial_in  input  1  UART line, idle high, LSB first.
REQ-007 Breq  output  1  bus request to arbiter.
REQ-008 Bgnt  input  1  bus grant from arbiter.
REQ-009 DataBus  inout  8  shared data bus; driven only during the write cycle, else high-Z.
REQ-010 AddressBus  inout  32  shared address bus; {zeros, address counter} during the write cycle, else high-Z.
REQ-011 ControlBus  inout  1  shared control; driven 1 (write) during the write cycle, else high-Z.
REQ-012 Overrun  output  1  sticky: a received byte was dropped because the FIFO was full.
REQ-013 FrameErr  output  1  sticky: a byte was dropped because the stop bit sampled low.

Function
REQ-014 Receiver states: IDLE, START, DATA, [PARITY], STOP; IDLE->START on Serial_in low.
REQ-015 START re-samples at CLKS_PER_BIT/2; if high, return to IDLE (glitch rejected, no error).
REQ-016 DATA samples 8 bits at bit centres (every CLKS_PER_BIT cycles), LSB first.
REQ-017 STOP samples at the bit centre: high -> push byte into FIFO; low -> drop byte and set FrameErr; either way -> IDLE.
REQ-018 FIFO: 4 entries x 8 bits; push when full drops the new byte, sets Overrun, and leaves contents unchanged.
REQ-019 Simultaneous push and pop on a full FIFO accepts the push without Overrun.
REQ-020 Bus FSM states: B_IDLE, B_REQ, B_XFER, B_REL.
REQ-021 B_IDLE->B_REQ when the FIFO is non-empty; Breq=1 registered from the B_REQ entry.
REQ-022 B_REQ waits indefinitely; on Bgnt=1 sampled -> B_XFER.
REQ-023 B_XFER lasts exactly 1 cycle: drive head byte, address and ControlBus=1; pop FIFO; increment address.
REQ-024 B_REL: Breq=0 and buses high-Z for one cycle, then -> B_IDLE; one byte per grant.
REQ-025 If Bgnt drops while in B_REQ before being sampled, the FSM stays in B_REQ.
REQ-026 The address counter wraps from 2^ADDR_BITS-1 to 0, not to BASE_ADDR.
REQ-027 Latency: the first XFER cycle occurs no earlier than 2 cycles after the push (push, B_REQ, grant sampled).

Reset
REQ-028 Reset: receiver IDLE, FIFO empty, bus FSM B_IDLE, Breq=0, all buses high-Z, address=BASE_ADDR, Overrun=0, FrameErr=0.
REQ-029 Reset mid-frame or mid-transfer aborts immediately; a partially received byte is discarded and no bus cycle completes.

Configuration
REQ-030 Macro UART_RCVR_PARITY_EN defined: a PARITY state between DATA and STOP checks even parity; on mismatch the byte is dropped and a sticky ParityErr output (1 bit, reset 0) is set.
REQ-031 Macro UART_RCVR_PARITY_EN undefined: frame is 8N1, no PARITY state, and no ParityErr port.

Structure
REQ-032 A shared package holds the receiver and bus state encodings, the FIFO depth (4) and the ControlBus write value (1).
REQ-033 The serial deserializer is the sub-module uart_rx_core (outputs a byte plus a valid pulse and error pulses); the FIFO and bus FSM sit in the top module.

Verification
REQ-034 Frame 0xA5 at 16 clk/bit, Bgnt tied to Breq -> one write cycle with DataBus=0xA5, AddressBus=0x00000000, ControlBus=1.
REQ-035 Five back-to-back frames with Bgnt held 0 -> 4 bytes buffered, Overrun=1; then grant -> 4 writes at addresses 0..3 in arrival order.
REQ-036 Frame with stop bit 0 -> FrameErr=1, no Breq, no bus drive.
REQ-037 BASE_ADDR=2^18-1, two frames -> writes at 0x3FFFF then 0x00000.
REQ-038 A 3-cycle low glitch on Serial_in -> no push, no error; Reset asserted mid-byte -> all outputs return to reset values next cycle.
REQ-039 With UART_RCVR_PARITY_EN, frame 0x03 with parity bit 1 -> ParityErr=1, byte dropped; parity bit 0 -> written normally.
